// File: rtl/iob_cache_line_refill_pkg.sv
// Shared definitions for the line refill sequencer: default geometry, derived-width helpers, FSM encoding.
package iob_cache_line_refill_pkg;

  localparam int DEF_ADDR_W        = 32;
  localparam int DEF_DATA_W        = 32;
  localparam int DEF_BE_DATA_W     = 64;
  localparam int DEF_WORD_OFFSET_W = 3;
  localparam int DEF_LINE_OFF_W    = 7;
  localparam int DEF_NWAYS_W       = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  function automatic int be_nbytes_w(input int be_data_w);
    return $clog2(be_data_w / 8);
  endfunction

  function automatic int line2be_w(input int word_offset_w, input int be_data_w, input int data_w);
    return word_offset_w - $clog2(be_data_w / data_w);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_off_w, input int word_offset_w,
                               input int data_w);
    return addr_w - line_off_w - word_offset_w - $clog2(data_w / 8);
  endfunction

  function automatic int raddr_w(input int addr_w, input int be_data_w, input int l2be_w);
    return addr_w - be_nbytes_w(be_data_w) - l2be_w;
  endfunction

  function automatic int max1(input int w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/iob_cache_line_refill_if.sv
// Miss / read-channel / data-memory / tag bundle of the line refill sequencer.
// The fwd_* signals exist only when IOB_CACHE_EARLY_FWD_EN is defined.
interface iob_cache_line_refill_if
  import iob_cache_line_refill_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BE_DATA_W     = DEF_BE_DATA_W,
  parameter int WORD_OFFSET_W = DEF_WORD_OFFSET_W,
  parameter int LINE_OFF_W    = DEF_LINE_OFF_W,
  parameter int NWAYS_W       = DEF_NWAYS_W
);
  localparam int LINE2BE_W = line2be_w(WORD_OFFSET_W, BE_DATA_W, DATA_W);
  localparam int TAG_W     = tag_w(ADDR_W, LINE_OFF_W, WORD_OFFSET_W, DATA_W);
  localparam int RADDR_W   = raddr_w(ADDR_W, BE_DATA_W, LINE2BE_W);
  localparam int RIDX_W    = max1(LINE2BE_W);

  logic                            miss_valid;
  logic [ADDR_W-1:0]               miss_addr;
  logic [NWAYS_W-1:0]              miss_way;
  logic                            miss_ready;
  logic                            replace_valid;
  logic [RADDR_W-1:0]              replace_addr;
  logic                            replace;
  logic                            read_valid;
  logic [RIDX_W-1:0]               read_addr;
  logic [BE_DATA_W-1:0]            read_rdata;
  logic                            mem_we;
  logic [NWAYS_W-1:0]              mem_way;
  logic [LINE_OFF_W+LINE2BE_W-1:0] mem_addr;
  logic [BE_DATA_W-1:0]            mem_wdata;
  logic                            tag_we;
  logic [TAG_W-1:0]                tag;
  logic                            refill_done;
`ifdef IOB_CACHE_EARLY_FWD_EN
  logic                            fwd_valid;
  logic [DATA_W-1:0]               fwd_data;
`endif

  // master: front-end + read channel side; slave: the refill sequencer
  modport master (
    output miss_valid, miss_addr, miss_way, replace, read_valid, read_addr, read_rdata,
    input  miss_ready, replace_valid, replace_addr, mem_we, mem_way, mem_addr, mem_wdata,
           tag_we, tag, refill_done
`ifdef IOB_CACHE_EARLY_FWD_EN
    , input fwd_valid, fwd_data
`endif
  );

  modport slave (
    input  miss_valid, miss_addr, miss_way, replace, read_valid, read_addr, read_rdata,
    output miss_ready, replace_valid, replace_addr, mem_we, mem_way, mem_addr, mem_wdata,
           tag_we, tag, refill_done
`ifdef IOB_CACHE_EARLY_FWD_EN
    , output fwd_valid, fwd_data
`endif
  );

endinterface

// File: rtl/iob_cache_refill_addr_split.sv
// Splits a latched miss byte address into tag, set index, beat-in-line, word-in-beat and line address.
module iob_cache_refill_addr_split
  import iob_cache_line_refill_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BE_DATA_W     = DEF_BE_DATA_W,
  parameter int WORD_OFFSET_W = DEF_WORD_OFFSET_W,
  parameter int LINE_OFF_W    = DEF_LINE_OFF_W,
  localparam int LINE2BE_W    = line2be_w(WORD_OFFSET_W, BE_DATA_W, DATA_W),
  localparam int TAG_W        = tag_w(ADDR_W, LINE_OFF_W, WORD_OFFSET_W, DATA_W),
  localparam int RADDR_W      = raddr_w(ADDR_W, BE_DATA_W, LINE2BE_W),
  localparam int WIB_BITS     = $clog2(BE_DATA_W / DATA_W),
  localparam int RIDX_W       = max1(LINE2BE_W),
  localparam int WIB_W        = max1(WIB_BITS)
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [TAG_W-1:0]      tag,
  output logic [LINE_OFF_W-1:0] set_idx,
  output logic [RIDX_W-1:0]     beat,
  output logic [WIB_W-1:0]      word,
  output logic [RADDR_W-1:0]    line
);
  localparam int WORD_LSB = $clog2(DATA_W / 8);

  assign tag     = addr[ADDR_W-1 -: TAG_W];
  assign set_idx = addr[WORD_LSB+WORD_OFFSET_W +: LINE_OFF_W];
  assign line    = addr[ADDR_W-1 -: RADDR_W];

  generate
    if (LINE2BE_W > 0) begin : g_beat
      assign beat = addr[WORD_LSB+WIB_BITS +: LINE2BE_W];
    end else begin : g_no_beat
      assign beat = '0;
    end
    if (WIB_BITS > 0) begin : g_word
      assign word = addr[WORD_LSB +: WIB_BITS];
    end else begin : g_no_word
      assign word = '0;
    end
    // Byte-in-word bits never matter to a line refill.
    if (WORD_LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^addr[WORD_LSB-1:0];
    end
  endgenerate

endmodule

// File: rtl/iob_cache_line_refill.sv
// Refill sequencer: latch a miss, request the line, pass each beat into the victim way, then commit the tag.
// IOB_CACHE_EARLY_FWD_EN adds a one-shot forward of the missed word when its beat first arrives.
module iob_cache_line_refill
  import iob_cache_line_refill_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BE_DATA_W     = DEF_BE_DATA_W,
  parameter int WORD_OFFSET_W = DEF_WORD_OFFSET_W,
  parameter int LINE_OFF_W    = DEF_LINE_OFF_W,
  parameter int NWAYS_W       = DEF_NWAYS_W
) (
  input logic                   clk_i,
  input logic                   reset_i,
  iob_cache_line_refill_if.slave bus
);
  localparam int LINE2BE_W = line2be_w(WORD_OFFSET_W, BE_DATA_W, DATA_W);
  localparam int TAG_W     = tag_w(ADDR_W, LINE_OFF_W, WORD_OFFSET_W, DATA_W);
  localparam int RADDR_W   = raddr_w(ADDR_W, BE_DATA_W, LINE2BE_W);
  localparam int RIDX_W    = max1(LINE2BE_W);
  localparam int WIB_W     = max1($clog2(BE_DATA_W / DATA_W));

  refill_state_t           state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [NWAYS_W-1:0]      way_q;
  logic                    accept, wr;
  logic                    miss_ready, replace_valid, tag_we, done;
  logic [TAG_W-1:0]        tag;
  logic [LINE_OFF_W-1:0]   set_idx;
  logic [RIDX_W-1:0]       beat;
  logic [WIB_W-1:0]        word;
  logic [RADDR_W-1:0]      line;

  iob_cache_refill_addr_split #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .BE_DATA_W    (BE_DATA_W),
    .WORD_OFFSET_W(WORD_OFFSET_W),
    .LINE_OFF_W   (LINE_OFF_W)
  ) u_split (
    .addr   (addr_q),
    .tag    (tag),
    .set_idx(set_idx),
    .beat   (beat),
    .word   (word),
    .line   (line)
  );

  assign accept = (state_q == IDLE) && bus.miss_valid;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= bus.miss_addr;
        way_q  <= bus.miss_way;
      end
    end
  end

  // Completion follows replace falling, not a beat count: error re-bursts keep replace high.
  always_comb begin
    state_d       = state_q;
    miss_ready    = 1'b0;
    replace_valid = 1'b0;
    wr            = 1'b0;
    tag_we        = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (bus.miss_valid) state_d = REQ;
      end
      REQ: begin
        replace_valid = 1'b1;
        if (bus.replace) state_d = FILL;
      end
      FILL: begin
        wr = bus.read_valid;
        if (!bus.replace) state_d = DONE;
      end
      DONE: begin
        tag_we  = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.miss_ready    = miss_ready;
  assign bus.replace_valid = replace_valid;
  assign bus.replace_addr  = line;
  assign bus.mem_we        = wr;
  assign bus.mem_way       = wr ? way_q : '0;
  assign bus.mem_wdata     = wr ? bus.read_rdata : '0;
  assign bus.tag_we        = tag_we;
  assign bus.tag           = tag;
  assign bus.refill_done   = done;

  generate
    if (LINE2BE_W > 0) begin : g_addr_beat
      assign bus.mem_addr = wr ? {set_idx, bus.read_addr} : '0;
    end else begin : g_addr_set
      assign bus.mem_addr = wr ? set_idx : '0;
    end
  endgenerate

`ifdef IOB_CACHE_EARLY_FWD_EN
  logic fwd_sent_q, fwd_hit;

  assign fwd_hit = wr && !fwd_sent_q && (bus.read_addr == beat);

  // One forward per refill, even if the read channel re-bursts the line.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      fwd_sent_q <= 1'b0;
    else if (accept)  fwd_sent_q <= 1'b0;
    else if (fwd_hit) fwd_sent_q <= 1'b1;
  end

  assign bus.fwd_valid = fwd_hit;
  assign bus.fwd_data  = bus.read_rdata[word*DATA_W +: DATA_W];
`else
  logic unused_fwd;
  assign unused_fwd = ^{beat, word};
`endif

endmodule

// File: tb/tb_iob_cache_line_refill.sv
// Directed bench for the line refill sequencer; a scoreboard queue holds expected write/forward/done events.
module tb_iob_cache_line_refill;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iob_cache_line_refill_if bus ();

  iob_cache_line_refill dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  // kind: 0 = data-memory write, 1 = tag commit + done, 2 = early forward
  typedef struct {
    int          kind;
    logic [8:0]  addr;
    logic        way;
    logic [63:0] data;
    logic [19:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int kind, input logic [8:0] addr, input logic way,
                          input logic [63:0] data, input logic [19:0] tag);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.way  = way;
    e.data = data;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic pop_exp(input string name, output exp_t e, output bit ok);
    ok = (exp_q.size() != 0);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: DUT event with empty scoreboard (t=%0t)", name, $time);
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  // Monitor: sample on the falling edge, pop one expectation per DUT event.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (bus.mem_we) begin
      check("we_needs_rvalid", 64'(bus.read_valid), 64'd1);
      pop_exp("write", e, ok);
      if (ok) begin
        check("wr_kind", 64'(e.kind), 64'd0);
        check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        check("wr_way", 64'(bus.mem_way), 64'(e.way));
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
`ifdef IOB_CACHE_EARLY_FWD_EN
    if (bus.fwd_valid) begin
      pop_exp("fwd", e, ok);
      if (ok) begin
        check("fwd_kind", 64'(e.kind), 64'd2);
        check("fwd_data", 64'(bus.fwd_data), 64'(e.data[31:0]));
      end
    end
`endif
    if (bus.tag_we || bus.refill_done) begin
      pop_exp("done", e, ok);
      if (ok) begin
        check("done_kind", 64'(e.kind), 64'd1);
        check("done_tag_we", 64'(bus.tag_we), 64'd1);
        check("done_pulse", 64'(bus.refill_done), 64'd1);
        check("done_tag", 64'(bus.tag), 64'(e.tag));
      end
    end
  end

  function automatic logic [63:0] beat_data(input int b, input int i);
    return {16'hBEEF, 8'(b), 8'(i), 16'hCAFE, 8'(b + 8'h10), 8'(i + 8'h20)};
  endfunction

  task automatic accept_miss(input logic [31:0] addr, input logic way);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    bus.miss_way   = way;
    @(negedge clk);
    check("idle_ready", 64'(bus.miss_ready), 64'd1);
    @(posedge clk); #1;
    bus.miss_valid = 1'b0;
  endtask

  // Called one step after the accepting edge (state REQ); returns one step into IDLE.
  task automatic serve_line(input logic [26:0] raddr, input logic [6:0] set_idx, input logic way,
                            input logic [19:0] tag, input int gap, input int bursts,
                            input logic [1:0] fbeat, input logic fword);
    logic [63:0] d;
    @(negedge clk);
    check("req_valid", 64'(bus.replace_valid), 64'd1);
    check("req_addr", 64'(bus.replace_addr), 64'(raddr));
    check("busy_not_ready", 64'(bus.miss_ready), 64'd0);
    @(posedge clk); #1;
    bus.replace = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < bursts; b++) begin
      for (int i = 0; i < 4; i++) begin
        d = beat_data(b, i);
        bus.read_valid = 1'b1;
        bus.read_addr  = 2'(i);
        bus.read_rdata = d;
        push_exp(0, {set_idx, 2'(i)}, way, d, 20'h0);
`ifdef IOB_CACHE_EARLY_FWD_EN
        if (b == 0 && fbeat == 2'(i)) push_exp(2, 9'h0, 1'b0, fword ? {32'h0, d[63:32]} : {32'h0, d[31:0]}, 20'h0);
`else
        if (fbeat == 2'(i) && fword && b < 0) push_exp(2, 9'h0, 1'b0, d, 20'h0);
`endif
        if (b == 0 && i == 0) begin
          @(negedge clk);
          check("single_request", 64'(bus.replace_valid), 64'd0);
        end
        @(posedge clk); #1;
        bus.read_valid = 1'b0;
        bus.read_rdata = ~d;
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
    end
    push_exp(1, 9'h0, 1'b0, 64'h0, tag);
    bus.replace = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("done_not_ready", 64'(bus.miss_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.miss_way   = '0;
    bus.replace    = 1'b0;
    bus.read_valid = 1'b0;
    bus.read_addr  = '0;
    bus.read_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
    check("rst_replace_valid", 64'(bus.replace_valid), 64'd0);
    check("rst_replace_addr", 64'(bus.replace_addr), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_tag_we", 64'(bus.tag_we), 64'd0);
    check("rst_done", 64'(bus.refill_done), 64'd0);
    check("rst_tag", 64'(bus.tag), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: 0x1234 way 1, back-to-back beats: set 0x11, tag 0x1, line addr 0x91, miss beat 2 word 1
    accept_miss(32'h0000_1234, 1'b1);
    serve_line(27'h91, 7'h11, 1'b1, 20'h1, 0, 1, 2'd2, 1'b1);

    // 2: 0x5678 way 0, 3-cycle gaps: set 0x33, tag 0x5, line 0x2B3, miss beat 3 word 0
    accept_miss(32'h0000_5678, 1'b0);
    serve_line(27'h2B3, 7'h33, 1'b0, 20'h5, 3, 1, 2'd3, 1'b0);

    // 3: re-burst without dropping replace: 8 writes, one commit; forward at most once
    accept_miss(32'h0ABC_DEF0, 1'b1);
    serve_line(27'h55E6F7, 7'h77, 1'b1, 20'h0ABCD, 1, 2, 2'd2, 1'b0);

    // 4: miss_valid held through the refill; the next address waits until after done
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_1234;
    bus.miss_way   = 1'b0;
    @(posedge clk); #1;
    bus.miss_addr  = 32'h0000_2000;
    bus.miss_way   = 1'b1;
    serve_line(27'h91, 7'h11, 1'b0, 20'h1, 0, 1, 2'd2, 1'b1);
    @(negedge clk);
    check("held_miss_ready_after_done", 64'(bus.miss_ready), 64'd1);
    @(posedge clk); #1;
    bus.miss_valid = 1'b0;
    serve_line(27'h100, 7'h00, 1'b1, 20'h2, 0, 1, 2'd0, 1'b0);

    // 5: reset after beat 1 of a fill: straight to IDLE, no commit
    accept_miss(32'h0000_0F40, 1'b0);
    @(negedge clk);
    check("t5_req_valid", 64'(bus.replace_valid), 64'd1);
    @(posedge clk); #1;
    bus.replace = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      bus.read_valid = 1'b1;
      bus.read_addr  = 2'(i);
      bus.read_rdata = beat_data(5, i);
      push_exp(0, {7'h7A, 2'(i)}, 1'b0, beat_data(5, i), 20'h0);
`ifdef IOB_CACHE_EARLY_FWD_EN
      if (i == 0) push_exp(2, 9'h0, 1'b0, {32'h0, beat_data(5, 0)}, 20'h0);
`endif
      @(posedge clk); #1;
    end
    bus.read_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_ready", 64'(bus.miss_ready), 64'd1);
    check("t5_no_tag_we", 64'(bus.tag_we), 64'd0);
    check("t5_no_done", 64'(bus.refill_done), 64'd0);
    check("t5_no_request", 64'(bus.replace_valid), 64'd0);
    bus.replace = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // 6: 0x101C: beat 3, word 1 -> forward of rdata[63:32] of beat 3 when enabled
    accept_miss(32'h0000_101C, 1'b1);
    serve_line(27'h80, 7'h00, 1'b1, 20'h1, 0, 1, 2'd3, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
